// File: rtl/cache_fill_pkg.sv
// cache_fill_pkg: shared state encoding and width helpers for the cache line fill controller
package cache_fill_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  function automatic int offs_w(input int words, input int bpw);
    return $clog2(words * bpw);
  endfunction

  function automatic int idx_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int cnt_w(input int words);
    return $clog2(words) + 1;
  endfunction

  localparam int DEF_WORDS_PER_BLOCK = 8;
  localparam int DEF_BYTES_PER_WORD  = 2;
  localparam int OFFS_W = offs_w(DEF_WORDS_PER_BLOCK, DEF_BYTES_PER_WORD);
  localparam int IDX_W  = idx_w(DEF_WORDS_PER_BLOCK);
  localparam int CNT_W  = cnt_w(DEF_WORDS_PER_BLOCK);

endpackage

// File: rtl/cache_fill_ctrl_block_addr_gen.sv
// block_addr_gen: maps (line base, start word, beat count) to a word address and in-line word index
module block_addr_gen #(
  parameter int ADDR_W          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int BYTES_PER_WORD  = 2
) (
  input  logic [ADDR_W-1:0]                  base_i,
  input  logic [$clog2(WORDS_PER_BLOCK)-1:0] start_i,
  input  logic [$clog2(WORDS_PER_BLOCK)-1:0] count_i,
  output logic [ADDR_W-1:0]                  addr_o,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] idx_o
);

  localparam int BW = $clog2(BYTES_PER_WORD);

  // index wraps naturally at its own width; base has its offset bits clear so OR acts as add
  always_comb begin
    idx_o  = start_i + count_i;
    addr_o = base_i | (ADDR_W'(idx_o) << BW);
  end

endmodule

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: handshake-driven cache line fill controller (optional CRITICAL_WORD_FIRST_EN)
module cache_fill_ctrl
  import cache_fill_pkg::*;
#(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int BYTES_PER_WORD  = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               miss_detected,
  input  logic [ADDR_W-1:0]                  miss_address,
  input  logic [DATA_W-1:0]                  memory_data,
  input  logic                               memory_data_valid,
  output logic                               fsm_busy,
  output logic                               memory_read,
  output logic [ADDR_W-1:0]                  memory_address,
  output logic                               write_data_array,
  output logic                               write_tag_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] word_index,
  output logic [DATA_W-1:0]                  write_data
);

  localparam int OFFS_W_P = offs_w(WORDS_PER_BLOCK, BYTES_PER_WORD);
  localparam int IDX_W_P  = idx_w(WORDS_PER_BLOCK);
  localparam int CNT_W_P  = cnt_w(WORDS_PER_BLOCK);
  localparam int BW       = $clog2(BYTES_PER_WORD);

  state_e               state_q, state_d;
  logic [CNT_W_P-1:0]   issue_q, issue_d, recv_q, recv_d;
  logic [ADDR_W-1:0]    base_q, base_d, issue_addr, recv_addr_unused;
  logic [IDX_W_P-1:0]   start_q, start_d, miss_start, recv_idx;
  logic                 start_fill, beat, last;

`ifdef CRITICAL_WORD_FIRST_EN
  assign miss_start = miss_address[OFFS_W_P-1:BW];
`else
  assign miss_start = '0;
`endif

  block_addr_gen #(
    .ADDR_W(ADDR_W), .WORDS_PER_BLOCK(WORDS_PER_BLOCK), .BYTES_PER_WORD(BYTES_PER_WORD)
  ) u_issue_gen (
    .base_i(base_q), .start_i(start_q), .count_i(issue_q[IDX_W_P-1:0]),
    .addr_o(issue_addr), .idx_o()
  );

  block_addr_gen #(
    .ADDR_W(ADDR_W), .WORDS_PER_BLOCK(WORDS_PER_BLOCK), .BYTES_PER_WORD(BYTES_PER_WORD)
  ) u_recv_gen (
    .base_i(base_q), .start_i(start_q), .count_i(recv_q[IDX_W_P-1:0]),
    .addr_o(recv_addr_unused), .idx_o(recv_idx)
  );

  // state register; reset abandons any fill without a tag write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state: the last beat always wins, otherwise issue runs a fixed count of cycles
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = miss_detected ? ISSUE : IDLE;
      ISSUE:   state_d = last ? IDLE : (issue_q == CNT_W_P'(WORDS_PER_BLOCK - 1)) ? DRAIN : ISSUE;
      DRAIN:   state_d = last ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end

  // outputs; state-derived ones clear with the async reset, input pass-throughs are gated by rst_n
  always_comb begin
    beat             = (state_q != IDLE) && memory_data_valid;
    last             = beat && (recv_q == CNT_W_P'(WORDS_PER_BLOCK - 1));
    fsm_busy         = rst_n && ((state_q == IDLE) ? miss_detected : !last);
    memory_read      = state_q == ISSUE;
    memory_address   = memory_read ? issue_addr : '0;
    write_data_array = beat;
    write_tag_array  = last;
    word_index       = beat ? recv_idx : '0;
    write_data       = rst_n ? memory_data : '0;
  end

  // datapath next values: capture line base and start word when a fill is accepted
  always_comb begin
    start_fill = (state_q == IDLE) && miss_detected;
    base_d     = start_fill ? (miss_address & ~ADDR_W'(WORDS_PER_BLOCK * BYTES_PER_WORD - 1)) : base_q;
    start_d    = start_fill ? miss_start : start_q;
    issue_d    = start_fill ? '0 : (state_q == ISSUE) ? issue_q + CNT_W_P'(1) : issue_q;
    recv_d     = start_fill ? '0 : beat ? recv_q + CNT_W_P'(1) : recv_q;
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q  <= '0;
      start_q <= '0;
      issue_q <= '0;
      recv_q  <= '0;
    end else begin
      base_q  <= base_d;
      start_q <= start_d;
      issue_q <= issue_d;
      recv_q  <= recv_d;
    end
  end

endmodule
